// File: rtl/nic2noc_vc_credit_tracker.sv
// rtl/nic2noc_vc_credit_tracker.sv - per-VC lifecycle, downstream credit tracking and flit admission toward the router
module nic2noc_vc_credit_tracker #(
    parameter int N_TOT_OF_VC    = 6,
    parameter int N_BITS_POINTER = 5,
    parameter int VC_DEPTH       = 4,
    parameter int N_BITS_CREDIT  = 3,
    parameter int FLIT_WIDTH     = 32,
    parameter bit REG_OUT        = 1'b1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [N_TOT_OF_VC-1:0]                credit_signal_i,
    input  logic [N_TOT_OF_VC-1:0]                free_signal_i,
    output logic [FLIT_WIDTH-1:0]                 out_link_o,
    output logic                                  is_valid_o,
    input  logic [N_TOT_OF_VC-1:0]                g_fifo_pointer_i,
    input  logic [N_TOT_OF_VC*N_BITS_POINTER-1:0] g_fifo_out_buffer_id_i,
    input  logic [N_TOT_OF_VC-1:0]                release_pointer_i,
    output logic [N_TOT_OF_VC-1:0]                credit_signal_o,
    output logic [N_TOT_OF_VC*N_BITS_POINTER-1:0] fifo_pointed_o,
    input  logic [FLIT_WIDTH-1:0]                 in_link_i,
    input  logic                                  is_valid_i,
    input  logic [N_TOT_OF_VC-1:0]                in_vc_i,
    input  logic                                  is_tail_i,
    output logic [N_TOT_OF_VC-1:0]                credit_avail_o,
    output logic [N_TOT_OF_VC-1:0]                fifo_pointer_state_o,
    output logic                                  error_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACTIVE    = 2'd1,
        TAIL_SENT = 2'd2
    } vc_state_t;

    localparam logic [N_BITS_CREDIT-1:0] DEPTH = N_BITS_CREDIT'(VC_DEPTH);

    logic [N_TOT_OF_VC-1:0] accept;
    logic [N_TOT_OF_VC-1:0] vc_err;
    logic                   accepted;
    logic                   drop;
    logic                   error_r;

    for (genvar i = 0; i < N_TOT_OF_VC; i++) begin : g_vc
        localparam logic [N_TOT_OF_VC-1:0] SEL = N_TOT_OF_VC'(1) << i;

        vc_state_t                 state_r;
        logic [N_BITS_CREDIT-1:0]  count_r;
        logic [N_BITS_POINTER-1:0] ptr_r;
        logic                      prop_r;
        logic [N_BITS_CREDIT:0]    eff_count;
        logic                      is_idle;
        logic                      overflow;
        logic                      free_bad;

        assign is_idle   = state_r == IDLE;
        assign accept[i] = is_valid_i && (in_vc_i == SEL) && (state_r == ACTIVE) && (count_r != '0);
        assign eff_count = {1'b0, count_r} + {{N_BITS_CREDIT{1'b0}}, credit_signal_i[i]};
        assign overflow  = credit_signal_i[i] && !accept[i] && (count_r == DEPTH);
        assign free_bad  = eff_count != {1'b0, DEPTH};

        // A free while still ACTIVE means the tail never went out; a free with credits missing means lost flits.
        assign vc_err[i] = is_idle ? (g_fifo_pointer_i[i] && free_signal_i[i])
                                   : (g_fifo_pointer_i[i] || overflow ||
                                      (free_signal_i[i] && (free_bad || state_r == ACTIVE)));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_r <= IDLE;
                count_r <= '0;
                ptr_r   <= '0;
            end else if (is_idle) begin
                if (g_fifo_pointer_i[i] && !free_signal_i[i]) begin
                    state_r <= ACTIVE;
                    count_r <= DEPTH;
                    ptr_r   <= g_fifo_out_buffer_id_i[i*N_BITS_POINTER +: N_BITS_POINTER];
                end
            end else if (free_signal_i[i]) begin
                state_r <= IDLE;
                count_r <= '0;
            end else begin
                if (credit_signal_i[i] && !accept[i] && !overflow) begin
                    count_r <= count_r + 1'b1;
                end else if (accept[i] && !credit_signal_i[i]) begin
                    count_r <= count_r - 1'b1;
                end
                if (accept[i] && is_tail_i) begin
                    state_r <= TAIL_SENT;
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                prop_r <= 1'b0;
            end else if (release_pointer_i[i]) begin
                prop_r <= 1'b0;
            end else if (is_idle && g_fifo_pointer_i[i] && !free_signal_i[i]) begin
                prop_r <= 1'b1;
            end
        end

        assign credit_signal_o[i]      = credit_signal_i[i] & prop_r;
        assign fifo_pointer_state_o[i] = !is_idle;
        assign credit_avail_o[i]       = (state_r == ACTIVE) && (count_r != '0);
        assign fifo_pointed_o[i*N_BITS_POINTER +: N_BITS_POINTER] = ptr_r;
    end

    assign accepted = |accept;
    assign drop     = is_valid_i && !accepted;

    if (REG_OUT) begin : g_reg_out
        logic [FLIT_WIDTH-1:0] link_r;
        logic                  valid_r;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                link_r  <= '0;
                valid_r <= 1'b0;
            end else begin
                valid_r <= accepted;
                if (accepted) begin
                    link_r <= in_link_i;
                end
            end
        end

        assign out_link_o = link_r;
        assign is_valid_o = valid_r;
    end else begin : g_comb_out
        assign out_link_o = in_link_i;
        assign is_valid_o = accepted;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            error_r <= 1'b0;
        end else if (drop || (|vc_err)) begin
            error_r <= 1'b1;
        end
    end

    assign error_o = error_r;

endmodule

// File: tb/tb_nic2noc_vc_credit_tracker.sv
// tb/tb_nic2noc_vc_credit_tracker.sv - scoreboard bench for registered and combinational output builds
module tb_nic2noc_vc_credit_tracker;

    localparam int NV = 6;
    localparam int NP = 5;
    localparam int D  = 4;
    localparam int FW = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NV-1:0]     credit_signal_i, free_signal_i, g_fifo_pointer_i, release_pointer_i, in_vc_i;
    logic [NV*NP-1:0]  ids;
    logic [FW-1:0]     in_link_i;
    logic              is_valid_i, is_tail_i;

    logic [FW-1:0]     link1, link0;
    logic              v1, v0, err1, err0;
    logic [NV-1:0]     cso1, cso0, avail1, avail0, st1, st0;
    logic [NV*NP-1:0]  ptd1, ptd0;

    nic2noc_vc_credit_tracker #(.N_TOT_OF_VC(NV), .N_BITS_POINTER(NP), .VC_DEPTH(D),
        .N_BITS_CREDIT(3), .FLIT_WIDTH(FW), .REG_OUT(1'b1)) dut_reg (
        .clk(clk), .rst(rst), .credit_signal_i(credit_signal_i), .free_signal_i(free_signal_i),
        .out_link_o(link1), .is_valid_o(v1), .g_fifo_pointer_i(g_fifo_pointer_i),
        .g_fifo_out_buffer_id_i(ids), .release_pointer_i(release_pointer_i),
        .credit_signal_o(cso1), .fifo_pointed_o(ptd1), .in_link_i(in_link_i),
        .is_valid_i(is_valid_i), .in_vc_i(in_vc_i), .is_tail_i(is_tail_i),
        .credit_avail_o(avail1), .fifo_pointer_state_o(st1), .error_o(err1));

    nic2noc_vc_credit_tracker #(.N_TOT_OF_VC(NV), .N_BITS_POINTER(NP), .VC_DEPTH(D),
        .N_BITS_CREDIT(3), .FLIT_WIDTH(FW), .REG_OUT(1'b0)) dut_comb (
        .clk(clk), .rst(rst), .credit_signal_i(credit_signal_i), .free_signal_i(free_signal_i),
        .out_link_o(link0), .is_valid_o(v0), .g_fifo_pointer_i(g_fifo_pointer_i),
        .g_fifo_out_buffer_id_i(ids), .release_pointer_i(release_pointer_i),
        .credit_signal_o(cso0), .fifo_pointed_o(ptd0), .in_link_i(in_link_i),
        .is_valid_i(is_valid_i), .in_vc_i(in_vc_i), .is_tail_i(is_tail_i),
        .credit_avail_o(avail0), .fifo_pointer_state_o(st0), .error_o(err0));

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [FW-1:0] data;
    } exp_t;

    exp_t q1[$];
    exp_t q0[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: 0 = free, 1 = sending, 2 = tail sent
    int   m_state[NV];
    int   m_cnt[NV];
    int   m_ptr[NV];
    bit   m_prop[NV];
    bit   m_err;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (v1) begin
            if (q1.size() == 0) begin
                chk("reg_spurious_valid", 64'(v1), 64'd0);
            end else begin
                e = q1.pop_front();
                chk("reg_flit_data", 64'(link1), 64'(e.data));
                chk("reg_flit_latency", 64'(cyc), 64'(e.due));
            end
        end else if (q1.size() > 0 && q1[0].due <= cyc) begin
            e = q1.pop_front();
            chk("reg_missing_valid", 64'(v1), 64'd1);
        end
        if (v0) begin
            if (q0.size() == 0) begin
                chk("comb_spurious_valid", 64'(v0), 64'd0);
            end else begin
                e = q0.pop_front();
                chk("comb_flit_data", 64'(link0), 64'(e.data));
                chk("comb_flit_latency", 64'(cyc), 64'(e.due));
            end
        end else if (q0.size() > 0 && q0[0].due <= cyc) begin
            e = q0.pop_front();
            chk("comb_missing_valid", 64'(v0), 64'd1);
        end
    end

    task automatic idle_in();
        credit_signal_i = '0; free_signal_i = '0; g_fifo_pointer_i = '0;
        release_pointer_i = '0; in_vc_i = '0; ids = '0; in_link_i = '0;
        is_valid_i = 1'b0; is_tail_i = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_state[i] = 0; m_cnt[i] = 0; m_ptr[i] = 0; m_prop[i] = 0;
        end
        m_err = 0;
    endtask

    function automatic logic [NV-1:0] m_accept();
        logic [NV-1:0] a = '0;
        for (int i = 0; i < NV; i++)
            if (is_valid_i && in_vc_i == NV'(1 << i) && m_state[i] == 1 && m_cnt[i] > 0) a[i] = 1'b1;
        return a;
    endfunction

    task automatic model_update(input logic [NV-1:0] acc);
        int n;
        if (is_valid_i && acc == '0) m_err = 1;
        for (int i = 0; i < NV; i++) begin
            int c = int'(credit_signal_i[i]);
            int a = int'(acc[i]);
            if (m_state[i] == 0) begin
                if (g_fifo_pointer_i[i] && free_signal_i[i]) m_err = 1;
                else if (g_fifo_pointer_i[i]) begin
                    m_state[i] = 1; m_cnt[i] = D; m_prop[i] = 1;
                    m_ptr[i] = int'(ids[i*NP +: NP]);
                end
            end else begin
                if (g_fifo_pointer_i[i]) m_err = 1;
                n = m_cnt[i] + c - a;
                if (n > D) begin n = D; m_err = 1; end
                if (free_signal_i[i]) begin
                    if (m_cnt[i] + c != D) m_err = 1;
                    if (m_state[i] == 1) m_err = 1;
                    m_state[i] = 0; m_cnt[i] = 0;
                end else begin
                    m_cnt[i] = n;
                    if (a == 1 && is_tail_i) m_state[i] = 2;
                end
            end
            if (release_pointer_i[i]) m_prop[i] = 0;
        end
    endtask

    // Entered just after a rising edge with inputs set; leaves just after the next rising edge.
    task automatic step();
        logic [NV-1:0]    acc, e_st, e_av, e_cso;
        logic [NV*NP-1:0] e_ptd;
        exp_t             e;
        acc = m_accept();
        if (acc != '0) begin
            e.data = in_link_i;
            e.due = cyc;     q0.push_back(e);
            e.due = cyc + 1; q1.push_back(e);
        end
        for (int i = 0; i < NV; i++) begin
            e_st[i]  = m_state[i] != 0;
            e_av[i]  = m_state[i] == 1 && m_cnt[i] > 0;
            e_cso[i] = credit_signal_i[i] & m_prop[i];
            e_ptd[i*NP +: NP] = NP'(m_ptr[i]);
        end
        @(negedge clk);
        chk("reg_state", 64'(st1), 64'(e_st));
        chk("comb_state", 64'(st0), 64'(e_st));
        chk("reg_credit_avail", 64'(avail1), 64'(e_av));
        chk("comb_credit_avail", 64'(avail0), 64'(e_av));
        chk("reg_credit_fwd", 64'(cso1), 64'(e_cso));
        chk("comb_credit_fwd", 64'(cso0), 64'(e_cso));
        chk("reg_pointed", 64'(ptd1), 64'(e_ptd));
        chk("comb_pointed", 64'(ptd0), 64'(e_ptd));
        chk("reg_error", 64'(err1), 64'(m_err));
        chk("comb_error", 64'(err0), 64'(m_err));
        model_update(acc);
        @(posedge clk);
        #1;
        idle_in();
    endtask

    task automatic do_reset();
        idle_in();
        #2;
        rst = 1'b1;
        q0.delete();
        q1.delete();
        model_reset();
        #1;
        chk("rst_reg_valid", 64'(v1), 64'd0);
        chk("rst_reg_link", 64'(link1), 64'd0);
        chk("rst_comb_valid", 64'(v0), 64'd0);
        chk("rst_state", 64'({st1, st0}), 64'd0);
        chk("rst_avail", 64'({avail1, avail0}), 64'd0);
        chk("rst_pointed", 64'({ptd1, ptd0}), 64'd0);
        chk("rst_error", 64'({err1, err0}), 64'd0);
        @(negedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic grant(input int vc, input int id);
        g_fifo_pointer_i[vc] = 1'b1;
        ids[vc*NP +: NP] = NP'(id);
        step();
    endtask

    task automatic send(input int vc, input bit tail);
        is_valid_i = 1'b1;
        in_vc_i = NV'(1 << vc);
        is_tail_i = tail;
        in_link_i = $urandom;
        step();
    endtask

    task automatic credits(input int vc, input int n);
        for (int k = 0; k < n; k++) begin
            credit_signal_i[vc] = 1'b1;
            step();
        end
    endtask

    task automatic rand_inputs(input bit legal);
        int cand[$];
        for (int i = 0; i < NV; i++) begin
            if (legal) begin
                g_fifo_pointer_i[i]  = (m_state[i] == 0) && ($urandom_range(5) == 0);
                credit_signal_i[i]   = (m_state[i] != 0) && (m_cnt[i] < D) && ($urandom_range(2) == 0);
                free_signal_i[i]     = (m_state[i] == 2) && (m_cnt[i] + int'(credit_signal_i[i]) == D)
                                       && ($urandom_range(1) == 0);
            end else begin
                g_fifo_pointer_i[i]  = $urandom_range(7) == 0;
                credit_signal_i[i]   = $urandom_range(2) == 0;
                free_signal_i[i]     = $urandom_range(15) == 0;
            end
            release_pointer_i[i] = $urandom_range(15) == 0;
            if (m_state[i] == 1 && m_cnt[i] > 0) cand.push_back(i);
        end
        ids = {$urandom, $urandom};
        in_link_i = $urandom;
        is_tail_i = $urandom_range(3) == 0;
        if (legal) begin
            is_valid_i = (cand.size() > 0) && ($urandom_range(1) == 0);
            if (is_valid_i) in_vc_i = NV'(1 << cand[$urandom_range(cand.size() - 1)]);
        end else begin
            is_valid_i = $urandom_range(1) == 0;
            if ($urandom_range(3) == 0) in_vc_i = NV'($urandom);
            else in_vc_i = NV'(1 << $urandom_range(NV - 1));
        end
    endtask

    initial begin
        idle_in();
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        grant(2, 17);
        chk("t1_state", 64'(st1), 64'b000100);
        chk("t1_pointed2", 64'(ptd1[2*NP +: NP]), 64'd17);
        chk("t1_avail2", 64'(avail1[2]), 64'd1);
        for (int k = 0; k < 4; k++) send(2, 1'b0);
        chk("t2_avail2_empty", 64'(avail1[2]), 64'd0);
        send(2, 1'b0);
        step();
        chk("t2_drop_error", 64'(err1), 64'd1);

        do_reset();
        grant(0, 3);
        send(0, 1'b0);
        credit_signal_i[0] = 1'b1;
        is_valid_i = 1'b1; in_vc_i = 6'b000001; in_link_i = $urandom;
        #1;
        chk("t3_fwd_propagating", 64'(cso1[0]), 64'd1);
        step();
        release_pointer_i[0] = 1'b1;
        step();
        credit_signal_i[0] = 1'b1;
        #1;
        chk("t3_fwd_released", 64'(cso1[0]), 64'd0);
        step();

        do_reset();
        for (int r = 0; r < 2; r++) begin
            grant(1, 9 + r);
            for (int k = 0; k < 3; k++) send(1, 1'b0);
            send(1, 1'b1);
            credits(1, 4 - r);
            free_signal_i[1] = 1'b1;
            step();
            chk("t4_idle", 64'(st1[1]), 64'd0);
            chk("t4_error", 64'(err1), 64'(r));
        end

        do_reset();
        grant(4, 21);
        send(4, 1'b0);
        do_reset();
        send(4, 1'b0);
        step();
        chk("t5_post_reset_drop", 64'(err1), 64'd1);

        do_reset();
        grant(3, 5);
        is_valid_i = 1'b1; in_vc_i = 6'b001000; in_link_i = 32'hA5A5_A5A5;
        #1;
        chk("t6_comb_valid", 64'(v0), 64'd1);
        chk("t6_comb_link", 64'(link0), 64'hA5A5_A5A5);
        step();
        credits(3, 2);
        chk("t6_overflow_error", 64'(err0), 64'd1);
        chk("t6_avail_held", 64'(avail0[3]), 64'd1);

        for (int ep = 0; ep < 8; ep++) begin
            do_reset();
            for (int k = 0; k < 300; k++) begin
                rand_inputs(ep % 2 == 0);
                step();
            end
            step();
        end

        step();
        chk("reg_queue_drained", 64'(q1.size()), 64'd0);
        chk("comb_queue_drained", 64'(q0.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/nic2noc_vc_credit_tracker.md
Name: nic2noc_vc_credit_tracker

Overview:
- Successor to the NIC-to-NoC pointer/credit-forwarding block.
- Keeps the per-VC out-buffer pointer and gated credit forwarding to the wishbone slave side.
- Adds per-VC downstream credit counters, a per-VC lifecycle FSM, flit admission/drop, an optional registered output stage and a sticky protocol-error flag.
- Sits between the wb_slave_interface and the router input link; feeds VC state to the vc_allocator.

Parameters:
- N_TOT_OF_VC, 6, `N_OF_VC*`N_OF_VN total VCs.
- N_BITS_POINTER, 5, out-buffer id width.
- VC_DEPTH, 4, downstream flit buffer depth per VC (credits loaded on grant); must be >= 1.
- N_BITS_CREDIT, 3, counter width; must be >= clog2(VC_DEPTH+1).
- REG_OUT, 1, 1 = registered flit output (latency 1); 0 = combinational (latency 0).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- credit_signal_i  in  N_TOT_OF_VC  downstream returns one credit for VC i.
- free_signal_i  in  N_TOT_OF_VC  downstream VC i buffer released.
- out_link_o  out  `FLIT_WIDTH  flit to router.
- is_valid_o  out  1  out_link_o valid.
- g_fifo_pointer_i  in  N_TOT_OF_VC  VC i allocated by VA.
- g_fifo_out_buffer_id_i  in  N_TOT_OF_VC*N_BITS_POINTER  out-buffer id for VC i; slice i = [(i+1)*N_BITS_POINTER-1 : i*N_BITS_POINTER].
- release_pointer_i  in  N_TOT_OF_VC  stop forwarding credits of VC i.
- credit_signal_o  out  N_TOT_OF_VC  forwarded credits.
- fifo_pointed_o  out  N_TOT_OF_VC*N_BITS_POINTER  latched out-buffer id per VC.
- in_link_i  in  `FLIT_WIDTH  flit from slave side.
- is_valid_i  in  1  in_link_i valid.
- in_vc_i  in  N_TOT_OF_VC  one-hot target VC of in_link_i.
- is_tail_i  in  1  in_link_i is a tail flit.
- credit_avail_o  out  N_TOT_OF_VC  VC i is ACTIVE with credit count > 0.
- fifo_pointer_state_o  out  N_TOT_OF_VC  1 = VC busy (state != IDLE).
- error_o  out  1  sticky protocol error.

Behaviour:
- Reset (async, immediate):
  - All FSMs IDLE; counters 0; pointers 0; propagate bits 0; error_o 0.
  - is_valid_o 0; out_link_o 0 when REG_OUT=1.
  - Reset mid-packet discards all state; an in-flight registered flit is lost.
- Per-VC FSM states: IDLE, ACTIVE, TAIL_SENT.
  - IDLE -> ACTIVE on g_fifo_pointer_i[i]: latch pointer slice; counter <= VC_DEPTH; propagate <= 1.
  - ACTIVE -> TAIL_SENT on an accepted flit with is_tail_i=1.
  - TAIL_SENT -> IDLE on free_signal_i[i].
  - ACTIVE -> IDLE on free_signal_i[i]; sets error.
  - Grant while not IDLE: ignored, sets error. Grant and free in the same cycle: free processed, grant ignored, error set.
- Flit acceptance:
  - Accept when is_valid_i & in_vc_i == one-hot i & state[i] == ACTIVE & count[i] > 0.
  - Otherwise, if is_valid_i: flit dropped (not forwarded) and error set. This covers zero-hot/multi-hot in_vc_i, idle VC, TAIL_SENT VC and zero credits.
- Credit counter (non-IDLE VCs only):
  - +1 on credit_signal_i[i]; -1 on an accepted flit; both in the same cycle -> unchanged.
  - Increment at VC_DEPTH without a simultaneous decrement: hold and set error.
  - credit_signal_i[i] in IDLE: ignored, not counted.
- Free check: free_signal_i[i] when the effective count (including a same-cycle credit) != VC_DEPTH sets error; the transition still occurs.
- Credit forwarding:
  - credit_signal_o = credit_signal_i & propagate_r (combinational).
  - propagate_r[i] set on an honoured grant, cleared on release_pointer_i[i]; release has priority if both occur in the same cycle.
- Output stage:
  - REG_OUT=1: is_valid_o/out_link_o registered from (accepted, in_link_i); out_link_o holds its last value when invalid.
  - REG_OUT=0: is_valid_o = accepted; out_link_o = in_link_i.
- fifo_pointed_o = pointer registers; fifo_pointer_state_o[i] = state[i] != IDLE; credit_avail_o registered-state derived (no combinational path from inputs).
- error_o: sticky until reset.

Test Plan:
- Grant VC2 with id 5'd17 -> next cycle fifo_pointer_state_o=6'b000100, fifo_pointed_o slice2=17, credit_avail_o[2]=1, count=4.
- VC2 active, send 4 flits with no credits (REG_OUT=1) -> 4 is_valid_o pulses, each 1 cycle late; credit_avail_o[2]=0. 5th flit dropped, is_valid_o stays 0, error_o=1.
- VC0 count 3: credit_signal_i[0] and a VC0 flit in the same cycle -> count stays 3; credit_signal_o[0]=1 while propagate is set. After release_pointer_i[0], a credit gives credit_signal_o[0]=0.
- VC1: send a tail flit, return 4 credits, then free_signal_i[1] -> IDLE, state bit 0, error_o=0. Repeat with only 3 credits returned -> IDLE and error_o=1.
- Assert rst asynchronously mid-packet (between clock edges) -> outputs reset immediately; after deassert, a flit to any VC is dropped with error_o=1.
- REG_OUT=0: accepted flit 0xA5.. -> is_valid_o and out_link_o equal the input in the same cycle; credit overflow (credit at count 4) -> count holds at 4, error_o=1.
